// File: rtl/uart_tx_ctrl_pkg.sv
// Shared constants for the UART transmit controller: bus widths, register
// offsets, STATUS bit positions and FSM state encodings.
`ifndef UART_TX_CTRL_DEFINES
`define UART_TX_CTRL_DEFINES
`define DataAddrBus 31:0
`define DataBus 31:0
`endif

package uart_tx_ctrl_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_CNT_LSB   = 3;
  localparam int ST_CNT_MSB   = 5;
  localparam int ST_OVF_BIT   = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A programmed divisor of zero behaves like one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide TX FIFO; DEPTH must be a power of two (>= 2) so pointers wrap
// naturally. A push into a full FIFO is accepted only alongside a pop.
module uart_tx_fifo
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: register decode, baud counter and frame
// FSM (start, 8 data bits LSB first, stop) fed from uart_tx_fifo.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter logic [15:0] CLK_DIV_RESET = 16'd434,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [`DataAddrBus] addr,
  input  logic [`DataBus]     data_i,
  input  logic [3:0]          sel,
  input  logic                we,
  input  logic                ce,
  output logic [`DataBus]     data_o,
  output logic                txd,
  output logic                irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          txd_q, txd_d;
  logic [15:0]   divisor_q, divisor_d;
  logic          ovf_q, ovf_d;

  logic          wr_en_s, rd_en_s;
  logic [1:0]    reg_sel_s;
  logic          push_s, pop_s, ovf_clr_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [7:0]    fifo_dout_s;
  logic [CW-1:0] fifo_count_s;
  logic          bit_end_s;
  logic [15:0]   reload_s;
  logic [31:0]   status_s;
  logic          unused_bits;

  assign wr_en_s   = ce & we;
  assign rd_en_s   = ce & ~we;
  assign reg_sel_s = addr[3:2];
  assign push_s    = wr_en_s & (reg_sel_s == REG_TXDATA) & sel[0];
  assign ovf_clr_s = wr_en_s & (reg_sel_s == REG_STATUS) & sel[0] & data_i[ST_OVF_BIT];
  assign bit_end_s = (cnt_q == 16'd0);
  assign reload_s  = eff_div(divisor_q) - 16'd1;

  // Only addr[3:2], data_i[15:0] and sel[1:0] carry meaning here.
  assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16], sel[3:2]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (data_i[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Divisor byte lanes and the sticky overflow flag.
  always_comb begin
    divisor_d = divisor_q;
    ovf_d     = ovf_q;
    if (wr_en_s && (reg_sel_s == REG_DIVISOR)) begin
      if (sel[0]) begin
        divisor_d[7:0] = data_i[7:0];
      end else begin
        divisor_d[7:0] = divisor_q[7:0];
      end
      if (sel[1]) begin
        divisor_d[15:8] = data_i[15:8];
      end else begin
        divisor_d[15:8] = divisor_q[15:8];
      end
    end else begin
      divisor_d = divisor_q;
    end
    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Frame FSM: every bit lasts reload_s+1 cycles, sampled at each bit boundary.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    pop_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_dout_s;
          cnt_d   = reload_s;
          txd_d   = 1'b0;
          state_d = S_START;
        end else begin
          txd_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
          cnt_d     = reload_s;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = reload_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_dout_s;
            cnt_d   = reload_s;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            cnt_d   = 16'd0;
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
      divisor_q <= CLK_DIV_RESET;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      divisor_q <= divisor_d;
      ovf_q     <= ovf_d;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_s                           = 32'd0;
    status_s[ST_FULL_BIT]              = fifo_full_s;
    status_s[ST_EMPTY_BIT]             = fifo_empty_s;
    status_s[ST_BUSY_BIT]              = (state_q != S_IDLE);
    status_s[ST_CNT_MSB:ST_CNT_LSB]    = 3'(fifo_count_s);
    status_s[ST_OVF_BIT]               = ovf_q;
  end

  // Combinational read port; zero whenever no read is addressed.
  always_comb begin
    data_o = 32'd0;
    if (rd_en_s) begin
      case (reg_sel_s)
        REG_STATUS:  data_o = status_s;
        REG_DIVISOR: data_o = {16'd0, divisor_q};
        REG_TXDATA:  data_o = 32'd0;
        REG_RSVD:    data_o = 32'd0;
        default:     data_o = 32'd0;
      endcase
    end else begin
      data_o = 32'd0;
    end
  end

  assign txd = txd_q;
  // Derived only from flops so bus activity cannot glitch it.
  assign irq = fifo_empty_s & (state_q == S_IDLE);

endmodule
